// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the INTA sequencer slice.
package pic_pkg;
  localparam int LVL_W = 3;
  localparam int VB_W = 5;
  typedef enum logic [1:0] {IDLE, PEND, ACK1, VEC} state_t;
  localparam logic [1:0] OCW2_NONE = 2'b00;
  localparam logic [1:0] OCW2_NSEOI = 2'b01;
  localparam logic [1:0] OCW2_SEOI = 2'b10;
  localparam logic [1:0] OCW2_RSVD = 2'b11;
  function automatic logic [7:0] onehot(input logic [LVL_W-1:0] l);
    return 8'b1 << l;
  endfunction
endpackage

// File: rtl/pic_isr_lowest.sv
// pic_isr_lowest: index of the lowest-numbered (highest-priority) set isr bit plus valid flag.
module pic_isr_lowest
  import pic_pkg::*;
(
  input  logic [7:0]       isr,
  output logic [LVL_W-1:0] lo,
  output logic             valid
);
  always_comb begin
    lo = '0;
    for (int i = 7; i >= 0; i--)
      if (isr[i]) lo = i[LVL_W-1:0];
  end
  assign valid = |isr;
endmodule

// File: rtl/inta_sequencer.sv
// inta_sequencer: 8259A-style INTA handshake, in-service tracking and vector drive.
// Define INTA_SEQ_AUTO_EOI_EN to let aeoi_mode clear the in-service bit during the vector cycle.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter logic [LVL_W-1:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_any,
  input  logic [LVL_W-1:0] req_level,
  input  logic             inta,
  input  logic [VB_W-1:0]  vec_base,
  input  logic             ocw2_wr,
  input  logic [1:0]       ocw2_cmd,
  input  logic [LVL_W-1:0] ocw2_level,
  input  logic             aeoi_mode,
  output logic             int_out,
  output logic [7:0]       isr,
  output logic [7:0]       irr_clr,
  output logic [7:0]       data_out,
  output logic             data_oe
);
  state_t state, next_state;
  logic [LVL_W-1:0] lvl, lo;
  logic lo_valid, spur, eligible, ack;
  logic [7:0] set_v, eoi_v, aeoi_v;
  pic_isr_lowest u_lowest (.isr(isr), .lo(lo), .valid(lo_valid));
  assign eligible = req_any && (!lo_valid || req_level < lo);
  assign ack = state == PEND && inta;
  assign set_v = ack && req_any ? onehot(req_level) : '0;
  always_comb
    eoi_v = !ocw2_wr ? '0 :
            ocw2_cmd == OCW2_NSEOI && lo_valid ? onehot(lo) :
            ocw2_cmd == OCW2_SEOI ? onehot(ocw2_level) : '0;
`ifdef INTA_SEQ_AUTO_EOI_EN
  assign aeoi_v = state == ACK1 && inta && aeoi_mode && !spur ? onehot(lvl) : '0;
`else
  logic unused_aeoi;
  assign unused_aeoi = aeoi_mode;
  assign aeoi_v = '0;
`endif
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = eligible ? PEND : IDLE;
      PEND: next_state = inta ? ACK1 : PEND;
      ACK1: next_state = inta ? VEC : ACK1;
      default: next_state = IDLE;
    endcase
  end
  // int_out stays up in PEND even if the request vanishes; only the first INTA drops it
  always_ff @(posedge clk)
    if (!reset) begin
      isr <= '0;
      irr_clr <= '0;
      int_out <= 1'b0;
      lvl <= '0;
      spur <= 1'b0;
    end else begin
      isr <= (isr & ~(eoi_v | aeoi_v)) | set_v;
      irr_clr <= set_v;
      int_out <= state == PEND && !inta;
      if (ack) begin
        lvl <= req_any ? req_level : SPURIOUS_LEVEL;
        spur <= !req_any;
      end
    end
  always_comb begin
    data_oe = state == VEC;
    data_out = data_oe ? {vec_base, lvl} : 8'h00;
  end
endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: vector table, corner-case sequences and randomized run against a reference model.
module tb_inta_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b0, req_any = 1'b0, inta = 1'b0, ocw2_wr = 1'b0, aeoi_mode = 1'b0;
  logic [2:0] req_level = '0, ocw2_level = '0;
  logic [4:0] vec_base = 5'h08;
  logic [1:0] ocw2_cmd = '0;
  logic int_out, data_oe;
  logic [7:0] isr, irr_clr, data_out;
  int checks = 0, failures = 0;

  inta_sequencer dut (
    .clk(clk), .reset(reset), .req_any(req_any), .req_level(req_level), .inta(inta),
    .vec_base(vec_base), .ocw2_wr(ocw2_wr), .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level),
    .aeoi_mode(aeoi_mode), .int_out(int_out), .isr(isr), .irr_clr(irr_clr),
    .data_out(data_out), .data_oe(data_oe)
  );

  typedef struct {
    logic rst_n, ra, ia, w;
    logic [2:0] rl, ol;
    logic [1:0] c;
    logic e_int, e_oe;
    logic [7:0] e_isr, e_irr, e_do;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst_n, ra, input logic [2:0] rl, input logic ia, w,
                     input logic [1:0] c, input logic [2:0] ol, input logic e_int,
                     input logic [7:0] e_isr, e_irr, e_do, input logic e_oe);
    vec_t v;
    v.rst_n = rst_n; v.ra = ra; v.rl = rl; v.ia = ia; v.w = w; v.c = c; v.ol = ol;
    v.e_int = e_int; v.e_isr = e_isr; v.e_irr = e_irr; v.e_do = e_do; v.e_oe = e_oe;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, ra, input logic [2:0] rl, input logic ia, w,
                       input logic [1:0] c, input logic [2:0] ol);
    reset = r; req_any = ra; req_level = rl; inta = ia; ocw2_wr = w; ocw2_cmd = c; ocw2_level = ol;
  endtask

  task automatic cyc(input logic ra, input logic [2:0] rl, input logic ia, w,
                     input logic [1:0] c, input logic [2:0] ol);
    drive(1'b1, ra, rl, ia, w, c, ol);
    @(posedge clk); #1;
  endtask

  // one full acknowledge of level l from idle: raise, wait, two INTA, return to idle
  task automatic ack_level(input logic [2:0] l);
    cyc(1, l, 0, 0, 0, 0);
    cyc(1, l, 0, 0, 0, 0);
    cyc(1, l, 1, 0, 0, 0);
    cyc(1, l, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  // reference model: phase counts how far the current interrupt has progressed
  int m_phase;
  logic [7:0] m_isr, m_irr;
  logic [2:0] m_lvl;
  logic m_int, m_spur;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  task automatic model_step();
    logic [7:0] set_b, clr_b;
    int ph;
    if (!reset) begin
      m_phase = 0; m_isr = 0; m_irr = 0; m_lvl = 0; m_int = 0; m_spur = 0;
      return;
    end
    set_b = (m_phase == 1 && inta && req_any) ? 8'(1 << req_level) : 8'h00;
    clr_b = 0;
    if (ocw2_wr && ocw2_cmd == 2'b01 && m_isr != 0) clr_b = 8'(1 << lowest(m_isr));
    if (ocw2_wr && ocw2_cmd == 2'b10) clr_b = 8'(1 << ocw2_level);
`ifdef INTA_SEQ_AUTO_EOI_EN
    if (m_phase == 2 && inta && aeoi_mode && !m_spur) clr_b |= 8'(1 << m_lvl);
`endif
    ph = m_phase;
    if (ph == 0 && req_any && int'(req_level) < lowest(m_isr)) m_phase = 1;
    if (ph == 1 && inta) begin
      m_phase = 2; m_lvl = req_any ? req_level : 3'd7; m_spur = !req_any;
    end
    if (ph == 2 && inta) m_phase = 3;
    if (ph == 3) m_phase = 0;
    m_int = ph == 1 && !inta;
    m_irr = set_b;
    m_isr = (m_isr & ~clr_b) | set_b;
  endtask

  initial begin
    add(0,1,3,0,0,0,0, 0,8'h00,8'h00,8'h00,0);
    add(1,1,3,0,0,0,0, 0,8'h00,8'h00,8'h00,0);
    add(1,1,3,0,0,0,0, 1,8'h00,8'h00,8'h00,0);
    add(1,1,3,1,0,0,0, 0,8'h08,8'h08,8'h00,0);
    add(1,1,3,0,0,0,0, 0,8'h08,8'h00,8'h00,0);
    add(1,1,3,1,0,0,0, 0,8'h08,8'h00,8'h43,1);
    add(1,1,3,0,0,0,0, 0,8'h08,8'h00,8'h00,0);
    add(1,1,5,0,0,0,0, 0,8'h08,8'h00,8'h00,0);
    add(1,1,5,0,1,1,0, 0,8'h00,8'h00,8'h00,0);
    add(1,1,5,0,0,0,0, 0,8'h00,8'h00,8'h00,0);
    add(1,1,5,0,0,0,0, 1,8'h00,8'h00,8'h00,0);
    add(1,0,5,0,0,0,0, 1,8'h00,8'h00,8'h00,0);
    add(1,0,5,1,0,0,0, 0,8'h00,8'h00,8'h00,0);
    add(1,0,5,1,0,0,0, 0,8'h00,8'h00,8'h47,1);
    add(1,0,0,0,0,0,0, 0,8'h00,8'h00,8'h00,0);
    add(0,0,0,0,0,0,0, 0,8'h00,8'h00,8'h00,0);
    add(1,1,2,0,0,0,0, 0,8'h00,8'h00,8'h00,0);
    add(1,1,2,0,0,0,0, 1,8'h00,8'h00,8'h00,0);
    add(1,1,2,1,0,0,0, 0,8'h04,8'h04,8'h00,0);
    add(0,1,2,1,1,2,2, 0,8'h00,8'h00,8'h00,0);
    add(1,0,0,1,0,0,0, 0,8'h00,8'h00,8'h00,0);
    add(1,0,0,1,0,0,0, 0,8'h00,8'h00,8'h00,0);
    @(negedge clk);
    foreach (tbl[k]) begin
      drive(tbl[k].rst_n, tbl[k].ra, tbl[k].rl, tbl[k].ia, tbl[k].w, tbl[k].c, tbl[k].ol);
      @(posedge clk); #1;
      chk($sformatf("row%0d int_out", k), {7'b0, int_out}, {7'b0, tbl[k].e_int});
      chk($sformatf("row%0d isr", k), isr, tbl[k].e_isr);
      chk($sformatf("row%0d irr_clr", k), irr_clr, tbl[k].e_irr);
      chk($sformatf("row%0d data_out", k), data_out, tbl[k].e_do);
      chk($sformatf("row%0d data_oe", k), {7'b0, data_oe}, {7'b0, tbl[k].e_oe});
    end

    // specific EOI among several in-service bits, then set-wins on a coincident clear
    drive(0, 0, 0, 0, 0, 0, 0); @(posedge clk); #1;
    ack_level(5);
    chk("seq isr after L5", isr, 8'h20);
    ack_level(0);
    chk("seq isr after L0 nest", isr, 8'h21);
    cyc(0, 0, 0, 1, 2'b10, 5);
    chk("seq specific EOI 5", isr, 8'h01);
    cyc(0, 0, 0, 1, 2'b11, 0);
    chk("seq reserved cmd", isr, 8'h01);
    cyc(0, 0, 0, 1, 2'b10, 0);
    chk("seq specific EOI 0", isr, 8'h00);
    cyc(0, 0, 0, 1, 2'b01, 0);
    chk("seq NSEOI on empty", isr, 8'h00);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("seq int_out L0", {7'b0, int_out}, 8'h01);
    cyc(1, 0, 1, 1, 2'b10, 0);
    chk("seq set wins isr", isr, 8'h01);
    chk("seq set wins irr_clr", irr_clr, 8'h01);
    cyc(1, 0, 1, 0, 0, 0);
    chk("seq vector L0", data_out, 8'h40);

    // automatic EOI in the vector cycle
    aeoi_mode = 1'b1;
    cyc(0, 0, 0, 1, 2'b10, 0);
    cyc(1, 6, 0, 0, 0, 0);
    cyc(1, 6, 0, 0, 0, 0);
    cyc(1, 6, 1, 0, 0, 0);
    chk("aeoi isr set", isr, 8'h40);
    cyc(1, 6, 1, 0, 0, 0);
    chk("aeoi data_oe", {7'b0, data_oe}, 8'h01);
`ifdef INTA_SEQ_AUTO_EOI_EN
    chk("aeoi isr cleared", isr, 8'h00);
`else
    chk("aeoi isr kept", isr, 8'h40);
`endif
    aeoi_mode = 1'b0;

    // randomized run against the model
    drive(0, 0, 0, 0, 0, 0, 0);
    model_step();
    @(posedge clk); #1;
    for (int n = 0; n < 4000; n++) begin
      reset = $urandom_range(0, 63) != 0;
      req_any = $urandom_range(0, 2) != 0;
      req_level = 3'($urandom);
      inta = $urandom_range(0, 2) == 0;
      vec_base = 5'($urandom);
      ocw2_wr = $urandom_range(0, 5) == 0;
      ocw2_cmd = 2'($urandom);
      ocw2_level = 3'($urandom);
      aeoi_mode = 1'($urandom);
      model_step();
      @(posedge clk); #1;
      chk("rnd int_out", {7'b0, int_out}, {7'b0, m_int});
      chk("rnd isr", isr, m_isr);
      chk("rnd irr_clr", irr_clr, m_irr);
      chk("rnd data_oe", {7'b0, data_oe}, {7'b0, m_phase == 3});
      chk("rnd data_out", data_out, m_phase == 3 ? {vec_base, m_lvl} : 8'h00);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
